// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: opcodes, ALU selects, FSM states and instruction decode for alu_pipeline_fwd
package alu_pipe_pkg;
  localparam logic [3:0] OPC_ADDI = 4'h0;
  localparam logic [3:0] OPC_SUBI = 4'h1;
  localparam logic [3:0] OPC_ANDI = 4'h2;
  localparam logic [3:0] OPC_ORI  = 4'h3;
  localparam logic [3:0] OPC_XORI = 4'h4;
  localparam logic [3:0] OPC_SLLI = 4'h5;
  localparam logic [3:0] OPC_SRLI = 4'h6;
  localparam logic [3:0] OPC_ADD  = 4'h7;
  localparam logic [3:0] OPC_SUB  = 4'h8;
  localparam logic [3:0] OPC_AND  = 4'h9;
  localparam logic [3:0] OPC_OR   = 4'hA;
  localparam logic [3:0] OPC_XOR  = 4'hB;
  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [2:0] alu_sel;
    logic       rd_we;
    logic       use_imm;
    logic       is_rtype;
    logic       is_halt;
    logic       is_nop;
  } dec_t;

  // I-type opcodes map 1:1 onto ALU selects; R-type repeats ADD..XOR from OPC_ADD
  function automatic dec_t decode(input logic [3:0] opc);
    dec_t d;
    d.is_halt  = opc == OPC_HALT;
    d.rd_we    = opc <= OPC_XOR;
    d.is_nop   = !d.rd_we && !d.is_halt;
    d.use_imm  = opc <= OPC_SRLI;
    d.is_rtype = d.rd_we && !d.use_imm;
    d.alu_sel  = d.use_imm ? opc[2:0] : d.is_rtype ? 3'(opc - OPC_ADD) : ALU_ADD;
    return d;
  endfunction
endpackage

// File: rtl/rf_bypass.sv
// rf_bypass: 16 x DWL register file, 2 read / 1 write, r0 fixed at 0, optional write-through
module rf_bypass #(
  parameter int DWL = 16,
  parameter bit FWD_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     ra,
  input  logic [3:0]     rb,
  output logic [DWL-1:0] da,
  output logic [DWL-1:0] db,
  input  logic           we,
  input  logic [3:0]     wa,
  input  logic [DWL-1:0] wd
);
  logic [DWL-1:0] mem [16];

  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 16; i++) mem[i] <= '0;
    else if (we && wa != 4'd0) mem[wa] <= wd;

  assign da = ra == 4'd0 ? '0 : FWD_EN && we && wa == ra ? wd : mem[ra];
  assign db = rb == 4'd0 ? '0 : FWD_EN && we && wa == rb ? wd : mem[rb];
endmodule

// File: rtl/alu_pipeline_fwd.sv
// alu_pipeline_fwd: ID/EX/WB ALU pipeline with valid/ready fetch, forwarding and HALT drain FSM
module alu_pipeline_fwd
  import alu_pipe_pkg::*;
#(
  parameter int DWL = 16,
  parameter bit FWD_EN = 1'b1,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            instr_valid,
  input  logic [15:0]     instr,
  output logic            instr_ready,
  input  logic            resume,
  output logic            halted,
  output logic            wb_valid,
  output logic [3:0]      wb_addr,
  output logic [DWL-1:0]  wb_data,
  output logic            wb_zero,
  output logic [CNTW-1:0] retired_count
);
  state_t state, state_nx;
  dec_t id_d;
  logic ifid_v, idex_v, idex_we, idex_rtype, idex_halt, exwb_halt;
  logic xfer, fwd_a, fwd_b, ex_wr;
  logic [15:0] ifid_i;
  logic [2:0] idex_sel;
  logic [3:0] idex_rd, idex_rs, idex_rt;
  logic [DWL-1:0] rd_a, rd_b, idex_a, idex_b, op_a, op_b, res;

  assign instr_ready = !RST && state == RUN;
  assign xfer = instr_valid && instr_ready;
  assign halted = state == HALTED;
  assign id_d = decode(ifid_i[15:12]);

  rf_bypass #(.DWL(DWL), .FWD_EN(FWD_EN)) u_rf (
    .clk(CLK), .rst(RST),
    .ra(ifid_i[7:4]), .rb(ifid_i[3:0]), .da(rd_a), .db(rd_b),
    .we(wb_valid), .wa(wb_addr), .wd(wb_data)
  );

  // rt is only a register source for R-type; for I-type the field is the immediate
  assign fwd_a = FWD_EN && wb_valid && wb_addr != 4'd0 && wb_addr == idex_rs;
  assign fwd_b = FWD_EN && wb_valid && wb_addr != 4'd0 && wb_addr == idex_rt && idex_rtype;
  assign op_a = fwd_a ? wb_data : idex_a;
  assign op_b = fwd_b ? wb_data : idex_b;
  assign ex_wr = idex_v && idex_we;

  assign res = idex_sel == ALU_ADD ? op_a + op_b :
               idex_sel == ALU_SUB ? op_a - op_b :
               idex_sel == ALU_AND ? op_a & op_b :
               idex_sel == ALU_OR  ? op_a | op_b :
               idex_sel == ALU_SLL ? op_a << idex_rt :
               idex_sel == ALU_SRL ? op_a >> idex_rt : op_a ^ op_b;

  always_comb
    state_nx = xfer && instr[15:12] == OPC_HALT ? DRAIN :
               state == DRAIN && exwb_halt     ? HALTED :
               state == HALTED && resume       ? RUN : state;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state         <= RUN;
      ifid_v        <= 1'b0;
      ifid_i        <= '0;
      idex_v        <= 1'b0;
      idex_sel      <= ALU_ADD;
      idex_we       <= 1'b0;
      idex_rtype    <= 1'b0;
      idex_halt     <= 1'b0;
      idex_rd       <= '0;
      idex_rs       <= '0;
      idex_rt       <= '0;
      idex_a        <= '0;
      idex_b        <= '0;
      exwb_halt     <= 1'b0;
      wb_valid      <= 1'b0;
      wb_addr       <= '0;
      wb_data       <= '0;
      wb_zero       <= 1'b0;
      retired_count <= '0;
    end else begin
      state         <= state_nx;
      ifid_v        <= xfer;
      ifid_i        <= xfer ? instr : '0;
      idex_v        <= ifid_v && !id_d.is_nop;
      idex_sel      <= id_d.alu_sel;
      idex_we       <= id_d.rd_we;
      idex_rtype    <= id_d.is_rtype;
      idex_halt     <= id_d.is_halt;
      idex_rd       <= ifid_i[11:8];
      idex_rs       <= ifid_i[7:4];
      idex_rt       <= ifid_i[3:0];
      idex_a        <= rd_a;
      idex_b        <= id_d.use_imm ? DWL'(ifid_i[3:0]) : rd_b;
      exwb_halt     <= idex_v && idex_halt;
      wb_valid      <= ex_wr;
      wb_addr       <= idex_rd;
      wb_data       <= res;
      wb_zero       <= ex_wr && res == '0;
      retired_count <= retired_count + CNTW'(wb_valid);
    end
endmodule

// File: tb/tb_alu_pipeline_fwd.sv
// tb_alu_pipeline_fwd: directed vectors against a forwarding DUT and a legacy (no-forwarding) DUT
module tb_alu_pipeline_fwd;
  logic clk = 1'b0, rst = 1'b0, instr_valid = 1'b0, resume = 1'b0;
  logic [15:0] instr = '0;
  logic ready, halted, wb_valid, wb_zero;
  logic [3:0] wb_addr;
  logic [31:0] wb_data;
  logic [15:0] count;
  logic l_ready, l_halted, l_wb_valid, l_wb_zero;
  logic [3:0] l_wb_addr;
  logic [31:0] l_wb_data;
  logic [15:0] l_count;
  int total = 0, bad = 0, cyc = 0;

  typedef struct {logic [3:0] a; logic [31:0] d; logic z; int c;} wb_t;
  wb_t q[$], ql[$];

  alu_pipeline_fwd #(.DWL(32), .FWD_EN(1'b1), .CNTW(16)) dut (
    .CLK(clk), .RST(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(ready),
    .resume(resume), .halted(halted), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_zero(wb_zero), .retired_count(count)
  );

  alu_pipeline_fwd #(.DWL(32), .FWD_EN(1'b0), .CNTW(16)) leg (
    .CLK(clk), .RST(rst), .instr_valid(instr_valid), .instr(instr), .instr_ready(l_ready),
    .resume(resume), .halted(l_halted), .wb_valid(l_wb_valid), .wb_addr(l_wb_addr),
    .wb_data(l_wb_data), .wb_zero(l_wb_zero), .retired_count(l_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wb_valid) q.push_back('{wb_addr, wb_data, wb_zero, cyc});
    if (l_wb_valid) ql.push_back('{l_wb_addr, l_wb_data, l_wb_zero, cyc});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [15:0] i);
    instr_valid = 1'b1;
    instr = i;
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    instr_valid = 1'b0;
    resume = 1'b0;
    idle(2);
    rst = 1'b0;
    q.delete();
    ql.delete();
  endtask

  task automatic expect_wb(input bit lg, input string tag, input logic [3:0] a,
                           input logic [31:0] d, input logic z, output int c, output logic [31:0] got_d);
    wb_t e;
    e = '{4'h0, 32'hDEAD_BEEF, 1'b0, -1};
    chk({tag, "_present"}, 32'((lg ? ql.size() : q.size()) != 0), 1);
    if (lg && ql.size() != 0) e = ql.pop_front();
    else if (!lg && q.size() != 0) e = q.pop_front();
    chk({tag, "_addr"}, 32'(e.a), 32'(a));
    chk({tag, "_data"}, e.d, d);
    chk({tag, "_zero"}, 32'(e.z), 32'(z));
    c = e.c;
    got_d = e.d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c0, c1, c2, c3;
    logic [31:0] d;
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 0);
    chk("rst_wb_valid", 32'(wb_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_halted", 32'(halted), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_ready_after", 32'(ready), 1);

    // back-to-back independent and distance-1/2 dependent
    do_reset();
    send(16'h0105);
    c0 = cyc;
    send(16'h0203);
    send(16'h7312);
    idle(4);
    expect_wb(0, "t1_r1", 4'd1, 32'd5, 1'b0, c1, d);
    expect_wb(0, "t1_r2", 4'd2, 32'd3, 1'b0, c2, d);
    expect_wb(0, "t1_r3", 4'd3, 32'd8, 1'b0, c3, d);
    chk("t1_latency", 32'(c1 - c0), 2);
    chk("t1_consec", 32'(c3 - c1), 2);
    chk("t1_count", 32'(count), 3);

    // dependent chain: forwarding vs legacy stale reads
    do_reset();
    send(16'h0101);
    repeat (3) send(16'h7111);
    idle(4);
    expect_wb(0, "t2_f1", 4'd1, 32'd1, 1'b0, c0, d);
    expect_wb(0, "t2_f2", 4'd1, 32'd2, 1'b0, c0, d);
    expect_wb(0, "t2_f3", 4'd1, 32'd4, 1'b0, c0, d);
    expect_wb(0, "t2_f4", 4'd1, 32'd8, 1'b0, c0, d);
    expect_wb(1, "t2_l1", 4'd1, 32'd1, 1'b0, c0, d);
    expect_wb(1, "t2_l2", 4'd1, 32'd0, 1'b1, c0, d);
    expect_wb(1, "t2_l3", 4'd1, 32'd0, 1'b1, c0, d);
    expect_wb(1, "t2_l4", 4'd1, 32'd2, 1'b0, c0, d);
    chk("t2_legacy_ne8", 32'(d != 32'd8), 1);

    // wrap, shifts and zero flag at DWL=32
    do_reset();
    send(16'h1401);
    send(16'h554F);
    send(16'hB644);
    send(16'h6754);
    idle(4);
    expect_wb(0, "t3_subi", 4'd4, 32'hFFFF_FFFF, 1'b0, c0, d);
    expect_wb(0, "t3_slli", 4'd5, 32'hFFFF_8000, 1'b0, c0, d);
    expect_wb(0, "t3_xor", 4'd6, 32'h0, 1'b1, c0, d);
    expect_wb(0, "t3_srli", 4'd7, 32'h0FFF_F800, 1'b0, c0, d);

    // HALT drain, resume ignored while draining, held instruction after resume
    do_reset();
    send(16'h0709);
    send(16'hF000);
    chk("t4_ready_drain", 32'(ready), 0);
    instr_valid = 1'b1;
    instr = 16'h0801;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("t4_halted_e1", 32'(halted), 0);
    tick();
    chk("t4_halted_e2", 32'(halted), 0);
    tick();
    chk("t4_halted_e3", 32'(halted), 1);
    chk("t4_ready_halted", 32'(ready), 0);
    expect_wb(0, "t4_r7", 4'd7, 32'd9, 1'b0, c0, d);
    chk("t4_no_extra", 32'(q.size()), 0);
    idle(2);
    chk("t4_still_halted", 32'(halted), 1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("t4_ready_resume", 32'(ready), 1);
    chk("t4_unhalted", 32'(halted), 0);
    tick();
    instr_valid = 1'b0;
    idle(3);
    expect_wb(0, "t4_r8", 4'd8, 32'd1, 1'b0, c0, d);
    chk("t4_count", 32'(count), 2);

    // r0 write suppression and NOP opcode
    do_reset();
    send(16'h0007);
    send(16'hD000);
    send(16'h7900);
    idle(4);
    expect_wb(0, "t5_r0", 4'd0, 32'd7, 1'b0, c0, d);
    expect_wb(0, "t5_r9", 4'd9, 32'd0, 1'b1, c0, d);
    chk("t5_no_nop_wb", 32'(q.size()), 0);
    chk("t5_count", 32'(count), 2);

    // asynchronous reset in the middle of DRAIN
    do_reset();
    send(16'h0105);
    idle(4);
    chk("t6_count_pre", 32'(count), 1);
    send(16'h0203);
    send(16'hF000);
    tick();
    chk("t6_wb_pre", 32'(wb_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_ready", 32'(ready), 0);
    chk("t6_wb_valid", 32'(wb_valid), 0);
    chk("t6_wb_data", wb_data, 0);
    chk("t6_wb_addr", 32'(wb_addr), 0);
    chk("t6_count", 32'(count), 0);
    chk("t6_halted", 32'(halted), 0);
    #2 rst = 1'b0;
    tick();
    chk("t6_ready_run", 32'(ready), 1);
    q.delete();
    send(16'h7311);
    idle(3);
    expect_wb(0, "t6_r3", 4'd3, 32'd0, 1'b1, c0, d);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
